// File: rtl/icache_nway_burst.sv
// N-way set-associative instruction cache with round-robin replacement,
// single-transaction INCR burst refill over AXI read and FENCE.I invalidate-all.
module icache_nway_burst #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAYS        = 4,
  parameter int SETS        = 64,
  parameter int BLOCK_WORDS = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              CPU_REQ,
  input  logic [ADDR_W-1:0] CPU_REQ_ADDR,
  output logic              CPU_REQ_VALID,
  output logic [DATA_W-1:0] CPU_REQ_DATA,
  output logic              CPU_REQ_ERR,
  input  logic              FLUSH,
  output logic              BUSY,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  output logic [7:0]        AR_LEN,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  input  logic              R_LAST,
  output logic              R_READY,
  output logic [2:0]        DBG_STATE
);

  localparam int WOFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - 2 - WOFF_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [DATA_W-1:0] NOP       = DATA_W'(32'h0000_0013);
  localparam logic [WOFF_W-1:0] LAST_BEAT = WOFF_W'(BLOCK_WORDS - 1);
  localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MREQ   = 3'd2,
    S_REFILL = 3'd3,
    S_RESP   = 3'd4,
    S_FLUSH  = 3'd5
  } state_t;

  state_t r_state;

  // Storage: data array is never reset, only the valid bits gate its use.
  logic [DATA_W-1:0] r_data    [WAYS][SETS*BLOCK_WORDS];
  logic [TAG_W-1:0]  r_tag_mem [WAYS][SETS];
  logic [SETS-1:0]   r_valid   [WAYS];
  logic [WAY_W-1:0]  r_rr      [SETS];

  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_req_tag;
  logic [WOFF_W-1:0] r_off;
  logic [WAY_W-1:0]  r_way;
  logic [WOFF_W-1:0] r_beat;
  logic              r_err;
  logic              r_flush_pend;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_ar_valid;
  logic [ADDR_W-1:0] r_ar_addr;
  logic              r_r_ready;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WOFF_W-1:0] w_off;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way;
  logic              w_has_inv;
  logic [WAY_W-1:0]  w_inv_way;
  logic [WAY_W-1:0]  w_victim;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_lookup_hit;
  logic              w_beat;
  logic              w_beat_last;
  logic              w_beat_err;
  logic              w_unused;

  assign w_tag    = CPU_REQ_ADDR[ADDR_W-1 -: TAG_W];
  assign w_idx    = CPU_REQ_ADDR[2+WOFF_W +: IDX_W];
  assign w_off    = CPU_REQ_ADDR[2 +: WOFF_W];
  assign w_unused = ^CPU_REQ_ADDR[1:0];

  // Descending scan leaves the lowest-numbered matching/invalid way selected.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w][w_idx] && (r_tag_mem[w][w_idx] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!r_valid[w][w_idx]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_victim     = w_has_inv ? w_inv_way : r_rr[w_idx];
  assign w_hit_data   = r_data[w_hit_way][{w_idx, w_off}];
  assign w_lookup_hit = (r_state == S_LOOKUP) && w_hit;

  // A beat is accepted only in REFILL, where R_READY is held high.
  assign w_beat      = (r_state == S_REFILL) && R_VALID;
  assign w_beat_last = (r_beat == LAST_BEAT);
  assign w_beat_err  = r_err || (R_RESP != 2'b00) || (R_LAST != w_beat_last);

  assign CPU_REQ_VALID = w_lookup_hit || (r_state == S_RESP);
  assign CPU_REQ_ERR   = (r_state == S_RESP) && r_err;
  assign CPU_REQ_DATA  = w_lookup_hit                      ? w_hit_data  :
                         ((r_state == S_RESP) && !r_err)   ? r_resp_data : NOP;
  assign BUSY          = !CPU_REQ_VALID;
  assign AR_VALID      = r_ar_valid;
  assign AR_ADDR       = r_ar_addr;
  assign AR_LEN        = 8'(BLOCK_WORDS - 1);
  assign R_READY       = r_r_ready;
  assign DBG_STATE     = r_state;

  always_ff @(posedge ACLK) begin
    if (w_beat) begin
      r_data[r_way][{r_idx, r_beat}] <= R_DATA;
      if (w_beat_last && !w_beat_err) begin
        r_tag_mem[r_way][r_idx] <= r_req_tag;
      end
    end
  end

  // Handshakes: AR completes when AR_VALID && AR_READY, an R beat when
  // R_VALID && R_READY; AR_VALID/AR_ADDR never change until accepted.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state      <= S_IDLE;
      r_valid      <= '{default: '0};
      r_rr         <= '{default: '0};
      r_idx        <= '0;
      r_req_tag    <= '0;
      r_off        <= '0;
      r_way        <= '0;
      r_beat       <= '0;
      r_err        <= 1'b0;
      r_flush_pend <= 1'b0;
      r_resp_data  <= NOP;
      r_ar_valid   <= 1'b0;
      r_ar_addr    <= '0;
      r_r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (FLUSH)        r_state <= S_FLUSH;
          else if (CPU_REQ) r_state <= S_LOOKUP;
        end
        S_LOOKUP: begin
          if (FLUSH) begin
            r_state <= S_FLUSH;
          end else if (w_hit) begin
            r_state <= CPU_REQ ? S_LOOKUP : S_IDLE;
          end else begin
            r_idx       <= w_idx;
            r_req_tag   <= w_tag;
            r_off       <= w_off;
            r_way       <= w_victim;
            r_rr[w_idx] <= (r_rr[w_idx] == LAST_WAY) ? '0 : r_rr[w_idx] + 1'b1;
            r_beat      <= '0;
            r_err       <= 1'b0;
            r_ar_addr   <= {w_tag, w_idx, {WOFF_W{1'b0}}, 2'b00};
            r_ar_valid  <= 1'b1;
            r_state     <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (AR_READY) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (R_VALID) begin
            r_beat <= r_beat + 1'b1;
            r_err  <= w_beat_err;
            if (r_beat == r_off) r_resp_data <= R_DATA;
            if (w_beat_last) begin
              r_r_ready <= 1'b0;
              r_state   <= S_RESP;
              if (!w_beat_err) r_valid[r_way][r_idx] <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if (r_flush_pend || FLUSH) r_state <= S_FLUSH;
          else if (CPU_REQ)          r_state <= S_LOOKUP;
          else                       r_state <= S_IDLE;
        end
        S_FLUSH: begin
          r_valid      <= '{default: '0};
          r_rr         <= '{default: '0};
          r_flush_pend <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (FLUSH && ((r_state == S_MREQ) || (r_state == S_REFILL))) begin
        r_flush_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_nway_burst.sv
// Directed bench for icache_nway_burst (WAYS=4, SETS=64, BLOCK_WORDS=8):
// the initial block plays both the fetch stage and the AXI read slave.
module tb_icache_nway_burst;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        CPU_REQ;
  logic [31:0] CPU_REQ_ADDR;
  logic        CPU_REQ_VALID;
  logic [31:0] CPU_REQ_DATA;
  logic        CPU_REQ_ERR;
  logic        FLUSH;
  logic        BUSY;
  logic        AR_VALID;
  logic [31:0] AR_ADDR;
  logic [7:0]  AR_LEN;
  logic        AR_READY;
  logic        R_VALID;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_LAST;
  logic        R_READY;
  logic [2:0]  DBG_STATE;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int lat;

  icache_nway_burst #(
    .DATA_W(32), .ADDR_W(32), .WAYS(4), .SETS(64), .BLOCK_WORDS(8)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .CPU_REQ(CPU_REQ), .CPU_REQ_ADDR(CPU_REQ_ADDR),
    .CPU_REQ_VALID(CPU_REQ_VALID), .CPU_REQ_DATA(CPU_REQ_DATA), .CPU_REQ_ERR(CPU_REQ_ERR),
    .FLUSH(FLUSH), .BUSY(BUSY),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_LEN(AR_LEN), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_LAST(R_LAST), .R_READY(R_READY),
    .DBG_STATE(DBG_STATE)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // AXI slave side of one refill; entered at a negedge with AR_VALID high.
  task automatic serve(input logic [31:0] line, input logic [31:0] base, input int err_beat,
                       input int last_beat, input int ar_wait, input int gap, input int flush_beat);
    chk("ar_addr", AR_ADDR, line);
    chk("ar_len", 32'(AR_LEN), 32'd7);
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge ACLK);
      chk("ar_hold_valid", 32'(AR_VALID), 32'd1);
      chk("ar_hold_addr", AR_ADDR, line);
    end
    AR_READY = 1'b1;
    @(negedge ACLK);
    AR_READY = 1'b0;
    chk("ar_drop", 32'(AR_VALID), 32'd0);
    chk("r_ready_on", 32'(R_READY), 32'd1);
    for (int b = 0; b < 8; b++) begin
      for (int g = 0; g < gap; g++) begin
        R_VALID = 1'b0;
        @(negedge ACLK);
      end
      R_VALID = 1'b1;
      R_DATA  = base + 32'(b);
      R_RESP  = (b == err_beat) ? 2'b10 : 2'b00;
      R_LAST  = (b == last_beat);
      FLUSH   = (b == flush_beat);
      @(negedge ACLK);
      FLUSH = 1'b0;
    end
    R_VALID = 1'b0;
    R_LAST  = 1'b0;
    R_RESP  = 2'b00;
    R_DATA  = '0;
  endtask

  // One fetch: present the address, serve a refill if one is requested,
  // score the response and leave CPU_REQ = more for the following cycle.
  task automatic fetch(input logic [31:0] addr, input bit more, input bit exp_miss,
                       input logic [31:0] exp_data, input bit exp_err, input logic [31:0] base,
                       input int err_beat, input int last_beat, input int ar_wait, input int gap,
                       input int flush_beat, output int lat_o);
    bit got;
    bit missed;
    logic [31:0] exp_v;
    got = 1'b0;
    missed = 1'b0;
    lat_o = -1;
    exp_q.push_back(exp_data);
    CPU_REQ = 1'b1;
    CPU_REQ_ADDR = addr;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (CPU_REQ_VALID) begin
        got = 1'b1;
        lat_o = c;
        break;
      end
      if (AR_VALID) begin
        missed = 1'b1;
        serve(addr & LINE_MASK, base, err_beat, last_beat, ar_wait, gap, flush_beat);
      end else begin
        @(negedge ACLK);
      end
    end
    exp_v = exp_q.pop_front();
    chk($sformatf("resp_seen@%h", addr), 32'(got), 32'd1);
    if (got) begin
      chk($sformatf("data@%h", addr), CPU_REQ_DATA, exp_v);
      chk($sformatf("err@%h", addr), 32'(CPU_REQ_ERR), 32'(exp_err));
      chk($sformatf("miss@%h", addr), 32'(missed), 32'(exp_miss));
      chk($sformatf("busy@%h", addr), 32'(BUSY), 32'd0);
      chk($sformatf("r_ready_off@%h", addr), 32'(R_READY), 32'd0);
    end
    CPU_REQ = more;
    @(negedge ACLK);
  endtask

  task automatic hit(input logic [31:0] addr, input bit more, input logic [31:0] exp_data,
                     output int lat_o);
    fetch(addr, more, 1'b0, exp_data, 1'b0, '0, -1, 7, 0, 0, -1, lat_o);
  endtask

  initial begin
    ARESETn = 1'b0;
    CPU_REQ = 1'b0;
    CPU_REQ_ADDR = '0;
    FLUSH = 1'b0;
    AR_READY = 1'b0;
    R_VALID = 1'b0;
    R_DATA = '0;
    R_RESP = 2'b00;
    R_LAST = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("rst_ar_valid", 32'(AR_VALID), 32'd0);
    chk("rst_r_ready", 32'(R_READY), 32'd0);
    chk("rst_ar_addr", AR_ADDR, 32'd0);
    chk("rst_valid", 32'(CPU_REQ_VALID), 32'd0);
    chk("rst_err", 32'(CPU_REQ_ERR), 32'd0);
    chk("rst_data", CPU_REQ_DATA, NOP);
    chk("rst_busy", 32'(BUSY), 32'd1);
    chk("rst_state", 32'(DBG_STATE), 32'd0);
    ARESETn = 1'b1;

    // Cold miss then an immediate hit in the same line
    fetch(32'h0000_1004, 1'b1, 1'b1, 32'hA1, 1'b0, 32'hA0, -1, 7, 0, 0, -1, lat);
    hit(32'h0000_1008, 1'b0, 32'hA2, lat);
    chk("hit_after_resp_lat", 32'(lat), 32'd0);

    // Eight sequential hits, one per cycle after the first lookup
    for (int i = 0; i < 8; i++) begin
      hit(32'h0000_1000 + 32'(4 * i), (i != 7), 32'hA0 + 32'(i), lat);
      chk($sformatf("seq_lat%0d", i), 32'(lat), (i == 0) ? 32'd1 : 32'd0);
    end

    // Index 0: tags 3,4,5 fill ways 1..3, tag 6 evicts way 0 (tag 2)
    fetch(32'h0000_1800, 1'b0, 1'b1, 32'hB0, 1'b0, 32'hB0, -1, 7, 0, 0, -1, lat);
    fetch(32'h0000_2000, 1'b0, 1'b1, 32'hC0, 1'b0, 32'hC0, -1, 7, 0, 0, -1, lat);
    fetch(32'h0000_2800, 1'b0, 1'b1, 32'hD0, 1'b0, 32'hD0, -1, 7, 0, 0, -1, lat);
    fetch(32'h0000_3000, 1'b0, 1'b1, 32'hE0, 1'b0, 32'hE0, -1, 7, 0, 0, -1, lat);
    hit(32'h0000_1804, 1'b0, 32'hB1, lat);
    hit(32'h0000_3008, 1'b0, 32'hE2, lat);
    fetch(32'h0000_1000, 1'b0, 1'b1, 32'hF0, 1'b0, 32'hF0, -1, 7, 0, 0, -1, lat);

    // Error response on beat 3, then a clean refill of the same line
    fetch(32'h0000_4024, 1'b0, 1'b1, NOP, 1'b1, 32'h10, 3, 7, 0, 0, -1, lat);
    fetch(32'h0000_4024, 1'b0, 1'b1, 32'h21, 1'b0, 32'h20, -1, 7, 0, 0, -1, lat);
    hit(32'h0000_4028, 1'b0, 32'h22, lat);

    // R_LAST arriving early is a protocol error
    fetch(32'h0000_9024, 1'b0, 1'b1, NOP, 1'b1, 32'h90, -1, 5, 0, 0, -1, lat);

    // AR backpressure and gaps between beats
    fetch(32'h0000_6044, 1'b0, 1'b1, 32'hA1, 1'b0, 32'hA0, -1, 7, 5, 2, -1, lat);

    // Flush mid-refill: response still delivered, then everything invalid
    fetch(32'h0000_7064, 1'b0, 1'b1, 32'h31, 1'b0, 32'h30, -1, 7, 0, 0, 4, lat);
    fetch(32'h0000_1804, 1'b0, 1'b1, 32'h41, 1'b0, 32'h40, -1, 7, 0, 0, -1, lat);

    // Reset in the middle of a burst
    CPU_REQ = 1'b1;
    CPU_REQ_ADDR = 32'h0000_8004;
    for (int c = 0; c < 20; c++) begin
      if (AR_VALID) break;
      @(negedge ACLK);
    end
    chk("mid_rst_ar_seen", 32'(AR_VALID), 32'd1);
    AR_READY = 1'b1;
    @(negedge ACLK);
    AR_READY = 1'b0;
    for (int b = 0; b < 3; b++) begin
      R_VALID = 1'b1;
      R_DATA = 32'h60 + 32'(b);
      @(negedge ACLK);
    end
    ARESETn = 1'b0;
    R_VALID = 1'b0;
    CPU_REQ = 1'b0;
    @(negedge ACLK);
    chk("mid_rst_ar_valid", 32'(AR_VALID), 32'd0);
    chk("mid_rst_r_ready", 32'(R_READY), 32'd0);
    chk("mid_rst_busy", 32'(BUSY), 32'd1);
    chk("mid_rst_state", 32'(DBG_STATE), 32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    fetch(32'h0000_8004, 1'b0, 1'b1, 32'h71, 1'b0, 32'h70, -1, 7, 0, 0, -1, lat);
    fetch(32'h0000_1008, 1'b0, 1'b1, 32'h82, 1'b0, 32'h80, -1, 7, 0, 0, -1, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_nway_burst.md
Name: icache_nway_burst

Overview:
Parametrised N-way set-associative instruction cache. Successor to the current 2-way, single-beat-refill I-cache.
- Sits between the fetch stage and an AXI read-only master port.
- Adds configurable associativity and line size, and single-transaction INCR burst refill (AR_LEN/R_LAST).
- Adds round-robin replacement, a FENCE.I invalidate-all, and refill error reporting.

Parameters:
DATA_W, 32, data/instruction width (fixed 32 for RV32)
ADDR_W, 32, address width
WAYS, 4, associativity; power of 2, 1..8
SETS, 64, sets per way; power of 2
BLOCK_WORDS, 8, words per line; power of 2, 2..16
(derived) WOFF_W = log2(BLOCK_WORDS), IDX_W = log2(SETS), TAG_W = ADDR_W-2-WOFF_W-IDX_W

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
CPU_REQ  in  1  fetch request; held with stable CPU_REQ_ADDR until CPU_REQ_VALID
CPU_REQ_ADDR  in  ADDR_W  fetch address; bits [1:0] ignored
CPU_REQ_VALID  out  1  response valid, one cycle per request
CPU_REQ_DATA  out  DATA_W  instruction; 32'h00000013 (NOP) when not valid or on error
CPU_REQ_ERR  out  1  refill returned an error response; qualified by CPU_REQ_VALID
FLUSH  in  1  single-cycle pulse: invalidate all lines (FENCE.I)
BUSY  out  1  cache cannot return data this cycle
AR_VALID  out  1  AXI read address valid
AR_ADDR  out  ADDR_W  line-aligned burst address
AR_LEN  out  8  constant BLOCK_WORDS-1
AR_READY  in  1  AXI
R_VALID  in  1  AXI
R_DATA  in  DATA_W  AXI
R_RESP  in  2  AXI; nonzero means error
R_LAST  in  1  AXI
R_READY  out  1  AXI read data ready

Behaviour:
- Reset (ARESETn=0 at ACLK edge):
  - all VALID bits 0, all RR pointers 0, state IDLE.
  - AR_VALID=0, R_READY=0, AR_ADDR=0, CPU_REQ_VALID=0, CPU_REQ_ERR=0, CPU_REQ_DATA=NOP, BUSY=1.
  - Reset during a refill abandons it; the partial line is never validated.
- Address split: TAG | INDEX | WORD_OFF | 2'b00.
- States: IDLE, LOOKUP, MREQ, REFILL, RESP, FLUSH.
- IDLE:
  - FLUSH goes to FLUSH.
  - Otherwise CPU_REQ goes to LOOKUP.
- LOOKUP: all ways compared in parallel.
  - Hit: CPU_REQ_VALID=1 combinationally in the same cycle; data from the hit way. Exactly one way hits (guaranteed by construction).
    - Next state is LOOKUP if CPU_REQ, else IDLE.
    - Back-to-back hits give one instruction per cycle.
  - Miss: latch index, tag, word offset and victim.
    - Victim is the lowest-numbered invalid way if any, else RR[INDEX]; RR[INDEX] then advances modulo WAYS.
    - Set AR_ADDR to the line-aligned address and AR_VALID=1; go to MREQ.
  - A FLUSH arriving in LOOKUP has priority over a new lookup: any hit this cycle still completes, then go to FLUSH.
- MREQ: AR_VALID held until AR_READY. On handshake, AR_VALID=0, R_READY=1, go to REFILL.
- REFILL:
  - R_READY=1 every cycle. Each R_VALID beat writes R_DATA to word BEAT_CNT of the victim line and increments BEAT_CNT.
  - Any beat with R_RESP!=0 sets a sticky error flag.
  - Completion is the beat with BEAT_CNT==BLOCK_WORDS-1. R_LAST on any other beat, or R_LAST absent on the final beat, also sets the error flag.
  - On completion: R_READY=0.
    - If no error: write tag, set VALID.
    - If error: leave VALID=0.
    - Go to RESP.
  - No critical-word-first; no early restart.
- RESP:
  - CPU_REQ_VALID=1 for one cycle, with the latched word, or with NOP and CPU_REQ_ERR=1 on error.
  - Next state is LOOKUP if CPU_REQ, else IDLE. A pending flush takes priority.
- FLUSH:
  - One cycle, clears all VALID bits and RR pointers, then goes to IDLE.
  - A FLUSH pulse during MREQ/REFILL/RESP is recorded as pending. The refill completes and its response is delivered, then FLUSH executes.
- BUSY = !(CPU_REQ_VALID).
- AR_LEN is constant; AR_ADDR is stable while AR_VALID=1.
- R beats outside REFILL are not accepted, because R_READY=0.
- Data array has no reset; only VALID gates use.

Test Plan:
- Cold miss, WAYS=4, BLOCK_WORDS=8: fetch 0x0000_1004 → one AR with AR_ADDR=0x0000_1000 and AR_LEN=7, then 8 beats 0xA0..0xA7 → RESP returns 0xA1. Following fetch 0x0000_1008 hits in LOOKUP the next cycle with 0xA2.
- Sequential hits: fetch 0x1000..0x101C on consecutive cycles after the fill → CPU_REQ_VALID high 8 consecutive cycles, no AR activity.
- Replacement: 5 distinct tags mapping to INDEX 0 → ways fill 0,1,2,3; the 5th evicts way 0 (RR). Re-fetching the first tag misses; the second tag still hits.
- Error: R_RESP=2'b10 on beat 3 → RESP with CPU_REQ_ERR=1 and data NOP. Re-fetching the same address misses again (line not valid).
- Backpressure: AR_READY held low 5 cycles, R_VALID gaps between beats → AR_ADDR/AR_VALID stable, beat count correct, same data as the cold-miss case.
- Flush: FLUSH pulse mid-REFILL → the refill completes and its response is delivered, then all lines are invalid. A prior hit address now misses. Reset asserted mid-burst → returns to IDLE with AR_VALID=0 and R_READY=0.
